// File: rtl/rv_mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package rv_mdu_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// The dividend is shifted out of the quotient register into the 33-bit
// partial remainder while quotient bits are shifted in from the right.
module mdu_divider
  import rv_mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            finished_o
);

  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fin_q, fin_d;

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] rem_diff;
  logic          fits;

  assign rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign fits      = ~rem_diff[XLEN];

  // Next-state: flush clears the step count, load restarts, step does one trial subtraction.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    fin_d = fin_q;
    if (flush_i) begin
      cnt_d = '0;
      fin_d = 1'b0;
    end else if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
      fin_d = 1'b0;
    end else if (step_i && !fin_q) begin
      rem_d = fits ? rem_diff : rem_shift;
      quo_d = {quo_q[XLEN-2:0], fits};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_STEP) begin
        fin_d = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      fin_q <= fin_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[XLEN-1:0];
  assign finished_o  = fin_q;

endmodule

// File: rtl/mdu_unit.sv
// RV32M multiply/divide unit for the execute stage.
// Multiply completes two cycles after accept; divide runs the iterative
// divider and completes 34 cycles after accept.
// Optional macro MDU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iterations and complete with the same latency as a multiply.
module mdu_unit
#(
  parameter int XLEN      = rv_mdu_pkg::XLEN,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  import rv_mdu_pkg::*;

  mdu_state_e state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            accept;
  logic            a_signed_in;
  logic            b_signed_in;
  logic            div_load;
  logic            div_step;
  logic            div_flush;
  logic            div_fin;
  logic            early_exit;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] op_res;
  logic [2*XLEN-1:0] prod;

  assign accept = (state_q == IDLE) && start_i && !flush_i;

  // MUL/MULH/MULHSU treat a as signed; DIV/REM treat both as signed.
  assign a_signed_in = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign b_signed_in = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];

  // Operands are extended with their captured sign so one unsigned multiply covers every variant.
  assign prod    = {{XLEN{sa_q}}, a_q} * {{XLEN{sb_q}}, b_q};
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign quo_fix = cond_negate(div_quo, sa_q ^ sb_q);
  assign rem_fix = cond_negate(div_rem, sa_q);

`ifdef MDU_DIV_EARLY_OUT_EN
  assign early_exit = dz_q || ovf_q;
`else
  assign early_exit = 1'b0;
`endif

  // Divide result with the architectural special cases taking priority over the iterated value.
  always_comb begin
    div_res = op_q[1] ? rem_fix : quo_fix;
    if (dz_q) begin
      div_res = op_q[1] ? a_q : DIV0_QUOT;
    end else if (ovf_q) begin
      div_res = op_q[1] ? '0 : INT_MIN;
    end
  end

  assign op_res = op_q[2] ? div_res : mul_res;

  mdu_divider #(
    .XLEN      (XLEN),
    .DIV_STEPS (DIV_STEPS)
  ) u_divider (
    .clk         (clk),
    .reset       (reset),
    .load_i      (div_load),
    .step_i      (div_step),
    .flush_i     (div_flush),
    .dividend_i  (cond_negate(a_i, a_signed_in & a_i[XLEN-1])),
    .divisor_i   (cond_negate(b_i, b_signed_in & b_i[XLEN-1])),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .finished_o  (div_fin)
  );

  // FSM next-state: accept and capture in IDLE, produce the result on leaving MUL/DIV, flush always wins.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    a_d       = a_q;
    b_d       = b_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    div_flush = 1'b0;
    if (flush_i) begin
      state_d   = IDLE;
      div_flush = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_d     = funct3_i;
            sa_d     = a_signed_in & a_i[XLEN-1];
            sb_d     = b_signed_in & b_i[XLEN-1];
            a_d      = a_i;
            b_d      = b_i;
            dz_d     = (b_i == '0);
            ovf_d    = !funct3_i[0] && (a_i == INT_MIN) && (b_i == DIV0_QUOT);
            div_load = funct3_i[2];
            state_d  = funct3_i[2] ? DIV : MUL;
          end
        end
        MUL: begin
          result_d = op_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
        DIV: begin
          if (early_exit || div_fin) begin
            result_d = op_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            div_step = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM and captured-operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign stall_o  = accept || (state_q == MUL) || (state_q == DIV);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit against an arithmetic reference model.
// Honours MDU_DIV_EARLY_OUT_EN when computing expected divide latency.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  mdu_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // Reference result straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa64, sb64, p;
    longint unsigned ua64, ub64, up;
    int              ia, ib;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    ia   = a;
    ib   = b;
    case (f)
      3'b000: begin p = sa64 * sb64; return p[31:0]; end
      3'b001: begin p = sa64 * sb64; return p[63:32]; end
      3'b010: begin p = sa64 * longint'(ub64); return p[63:32]; end
      3'b011: begin up = ua64 * ub64; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from accept to the done pulse.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
`ifdef MDU_DIV_EARLY_OUT_EN
    if (b == 0) return 2;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
`endif
    return 34;
  endfunction

  // Issues one operation and watches it to completion; lat=0 means no done pulse seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    stall_ok = 1'b1;
    lat      = 0;
    res      = 'x;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f;
    a_i      = a;
    b_i      = b;
    #1;
    if (stall_o !== 1'b1) stall_ok = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (done_o === 1'b1) begin
        lat = k;
        res = result_o;
        if (stall_o !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want);
    logic [31:0] res;
    int          lat;
    bit          sok;
    int          want_lat;
    want_lat = ref_latency(f, a, b);
    run_op(f, a, b, res, lat, sok);
    checks++;
    if (res !== want) begin
      errors++;
      $display("[TB] FAIL %s result: got %h expected %h", name, res, want);
    end
    checks++;
    if (lat !== want_lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, want_lat);
    end
    checks++;
    if (sok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s stall window: got %0d expected 1", name, sok);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = 3'b000;
    a_i      = '0;
    b_i      = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (result_o !== 32'd0) begin errors++; $display("[TB] FAIL reset result: got %h expected 0", result_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done_o); end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset stall: got %b expected 0", stall_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    applyStimulus("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    applyStimulus("MULH -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    applyStimulus("MULHSU -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    applyStimulus("DIV -20/3", 3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA);
    applyStimulus("REM -20/3", 3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE);
    applyStimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
    applyStimulus("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_special();
    applyStimulus("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF);
    applyStimulus("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5);
    applyStimulus("DIV min/-1", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    applyStimulus("REM min/-1", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      applyStimulus($sformatf("random%0d f=%0d a=%h b=%h", i, f, a, b), f, a, b, ref_result(f, a, b));
    end
  endtask

  task automatic test_flush();
    bit saw;
    applyStimulus("pre-flush MUL 3*5", 3'b000, 32'd3, 32'd5, 32'd15);
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b100;
    a_i      = 32'd1000;
    b_i      = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush idle stall: got %b expected 0", stall_o); end
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_o !== 1'b0 || stall_o !== 1'b0) saw = 1'b1;
      @(negedge clk);
      #1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("[TB] FAIL flush activity after abort: got %b expected 0", saw); end
    checks++;
    if (result_o !== 32'd15) begin errors++; $display("[TB] FAIL flush result kept: got %h expected %h", result_o, 32'd15); end
    @(negedge clk);
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd4;
    b_i      = 32'd4;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush+start stall: got %b expected 0", stall_o); end
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    saw     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (done_o !== 1'b0 || stall_o !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("[TB] FAIL flush+start accepted: got %b expected 0", saw); end
    applyStimulus("post-flush DIV 1000/7", 3'b100, 32'd1000, 32'd7, 32'd142);
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus("pre-reset MUL 9*9", 3'b000, 32'd9, 32'd9, 32'd81);
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b001;
    a_i      = 32'd2;
    b_i      = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (result_o !== 32'd0) begin errors++; $display("[TB] FAIL async reset result: got %h expected 0", result_o); end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL async reset stall: got %b expected 0", stall_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL async reset done: got %b expected 0", done_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          lat1, lat2;
    logic [31:0] res1, res2;
    logic        stall_done;
    lat1 = 0;
    lat2 = 0;
    res1 = 'x;
    res2 = 'x;
    stall_done = 1'bx;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'd1000;
    b_i      = 32'd7;
    @(negedge clk);
    funct3_i = 3'b000;
    a_i      = 32'd6;
    b_i      = 32'd7;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (done_o === 1'b1) begin
        lat1 = k;
        res1 = result_o;
        stall_done = stall_o;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat1 !== 34) begin errors++; $display("[TB] FAIL b2b first latency: got %0d expected 34", lat1); end
    checks++;
    if (res1 !== 32'd142) begin errors++; $display("[TB] FAIL b2b first result: got %h expected %h", res1, 32'd142); end
    checks++;
    if (stall_done !== 1'b0) begin errors++; $display("[TB] FAIL b2b stall in done: got %b expected 0", stall_done); end
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b second accept stall: got %b expected 1", stall_o); end
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (done_o === 1'b1) begin
        lat2 = k;
        res2 = result_o;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat2 !== 2) begin errors++; $display("[TB] FAIL b2b second latency: got %0d expected 2", lat2); end
    checks++;
    if (res2 !== 32'd42) begin errors++; $display("[TB] FAIL b2b second result: got %h expected %h", res2, 32'd42); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
